// File: rtl/intra_mode_sel_if.sv
// Block/result bus between the prediction sample generator, the bench or host, and intra_mode_sel.
interface intra_mode_sel_if;
  logic         start;
  logic [0:127] pre_sam;
  logic         pre_valid;
  logic [0:127] org_blk;
  logic         busy;
  logic [5:0]   best_mode;
  logic [11:0]  best_cost;
  logic         done;

  modport master (
    output start, pre_sam, pre_valid, org_blk,
    input  busy, best_mode, best_cost, done
  );

  modport slave (
    input  start, pre_sam, pre_valid, org_blk,
    output busy, best_mode, best_cost, done
  );
endinterface

// File: rtl/intra_mode_sel.sv
// 4x4 intra mode decision: 3-stage SAD pipeline over 35 predicted blocks, keeps the min-cost mode.
// Optional macro INTRA_SEL_ANG_BIAS_EN adds a +4 cost bias to angular modes (2..34).
module intra_mode_sel (
  input  logic            clk,
  input  logic            rst,
  intra_mode_sel_if.slave bus
);

  localparam int unsigned NUM_SAMP  = 16;
  localparam int unsigned SAMP_W    = 8;
  localparam int unsigned MODE_W    = 6;
  localparam int unsigned COST_W    = 12;
  localparam int unsigned DRAIN_W   = 2;
  localparam int unsigned LAST_MODE = 34;

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [MODE_W-1:0]    mode_cnt_q, mode_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [MODE_W-1:0]    best_mode_q, best_mode_d;
  logic [COST_W-1:0]    best_cost_q, best_cost_d;
  logic                 clr_run;

  logic [SAMP_W-1:0]    ad_q [NUM_SAMP];
  logic [SAMP_W-1:0]    ad_d [NUM_SAMP];
  logic                 s1_vld_q, s1_vld_d;
  logic [MODE_W-1:0]    s1_tag_q, s1_tag_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [MODE_W-1:0]    s2_tag_q, s2_tag_d;
  logic [COST_W-1:0]    s2_cost_q, s2_cost_d;
  logic [MODE_W-1:0]    run_mode_q, run_mode_d;
  logic [COST_W-1:0]    run_cost_q, run_cost_d;
  logic [COST_W-1:0]    sum_c;

  // Control FSM and registered outputs
  always_comb begin
    state_d     = state_q;
    mode_cnt_d  = mode_cnt_q;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    best_mode_d = best_mode_q;
    best_cost_d = best_cost_q;
    clr_run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SEARCH;
          mode_cnt_d = '0;
          busy_d     = 1'b1;
          clr_run    = 1'b1;
        end
      end
      SEARCH: begin
        if (bus.pre_valid) begin
          mode_cnt_d = mode_cnt_q + MODE_W'(1);
          if (mode_cnt_q == MODE_W'(LAST_MODE)) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        // Third drain edge: run state settled one edge earlier, latch the result.
        if (drain_cnt_q == DRAIN_W'(2)) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          best_mode_d = run_mode_q;
          best_cost_d = run_cost_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // S1: per-sample absolute differences
  always_comb begin
    for (int k = 0; k < NUM_SAMP; k++) begin
      ad_d[k] = (bus.pre_sam[k*SAMP_W +: SAMP_W] > bus.org_blk[k*SAMP_W +: SAMP_W]) ?
                (bus.pre_sam[k*SAMP_W +: SAMP_W] - bus.org_blk[k*SAMP_W +: SAMP_W]) :
                (bus.org_blk[k*SAMP_W +: SAMP_W] - bus.pre_sam[k*SAMP_W +: SAMP_W]);
    end
    s1_vld_d = (state_q == SEARCH) && bus.pre_valid;
    s1_tag_d = mode_cnt_q;
  end

  // S2: adder tree plus optional angular bias
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_SAMP; k++) begin
      sum_c = sum_c + COST_W'(ad_q[k]);
    end
    s2_vld_d = s1_vld_q;
    s2_tag_d = s1_tag_q;
`ifdef INTRA_SEL_ANG_BIAS_EN
    s2_cost_d = sum_c + ((s1_tag_q >= MODE_W'(2)) ? COST_W'(4) : COST_W'(0));
`else
    s2_cost_d = sum_c;
`endif
  end

  // S3: strict less-than keeps the lowest mode on ties
  always_comb begin
    run_mode_d = run_mode_q;
    run_cost_d = run_cost_q;
    if (clr_run) begin
      run_mode_d = '0;
      run_cost_d = '1;
    end else if (s2_vld_q && (s2_cost_q < run_cost_q)) begin
      run_mode_d = s2_tag_q;
      run_cost_d = s2_cost_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_cnt_q  <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_mode_q <= '0;
      best_cost_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_tag_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_tag_q    <= '0;
      s2_cost_q   <= '0;
      run_mode_q  <= '0;
      run_cost_q  <= '1;
    end else begin
      state_q     <= state_d;
      mode_cnt_q  <= mode_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      best_mode_q <= best_mode_d;
      best_cost_q <= best_cost_d;
      s1_vld_q    <= s1_vld_d;
      s1_tag_q    <= s1_tag_d;
      s2_vld_q    <= s2_vld_d;
      s2_tag_q    <= s2_tag_d;
      s2_cost_q   <= s2_cost_d;
      run_mode_q  <= run_mode_d;
      run_cost_q  <= run_cost_d;
    end
  end

  // Difference registers carry no control meaning, so they skip reset.
  always_ff @(posedge clk) begin
    ad_q <= ad_d;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.best_mode = best_mode_q;
  assign bus.best_cost = best_cost_q;

endmodule

// File: tb/tb_intra_mode_sel.sv
// Directed bench for intra_mode_sel; expected results are hand-derived per test pattern.
module tb_intra_mode_sel;

`ifdef INTRA_SEL_ANG_BIAS_EN
  localparam int BIAS = 4;
`else
  localparam int BIAS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;
  logic [0:127] pre_tab [35];

  intra_mode_sel_if bus();

  intra_mode_sel dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:127] blk_fill(input int v);
    logic [0:127] b;
    for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(v);
    return b;
  endfunction

  function automatic logic [0:127] blk_ramp(input int off);
    logic [0:127] b;
    for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(k*8 + off);
    return b;
  endfunction

  // Block whose samples exceed base by a total of n, spread as evenly as possible.
  function automatic logic [0:127] blk_sad(input int base, input int n);
    logic [0:127] b;
    for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(base + n/16 + ((k < n%16) ? 1 : 0));
    return b;
  endfunction

  function automatic int cost_of(input int mode, input int sad);
    return sad + ((mode >= 2) ? BIAS : 0);
  endfunction

  task automatic do_search(input string tag, input bit gaps, input int exp_mode, input int exp_cost);
    int lat;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check({tag, ":busy_start"}, int'(bus.busy), 1);
    for (int m = 0; m < 35; m++) begin
      bus.pre_sam   = pre_tab[m];
      bus.pre_valid = 1'b1;
      step();
      if (gaps && m < 34) begin
        bus.pre_valid = 1'b0;
        bus.pre_sam   = bus.org_blk;
        step();
      end
    end
    check({tag, ":busy_last"}, int'(bus.busy), 1);
    // Zero-SAD beats during drain must be ignored.
    bus.pre_valid = 1'b1;
    bus.pre_sam   = bus.org_blk;
    lat = 0;
    while (!bus.done && lat < 10) begin
      step();
      lat++;
    end
    check({tag, ":latency"}, lat, 3);
    check({tag, ":best_mode"}, int'(bus.best_mode), exp_mode);
    check({tag, ":best_cost"}, int'(bus.best_cost), exp_cost);
    bus.pre_valid = 1'b0;
    step();
    check({tag, ":done_pulse"}, int'(bus.done), 0);
    check({tag, ":busy_end"}, int'(bus.busy), 0);
    check({tag, ":best_hold"}, int'(bus.best_mode), exp_mode);
  endtask

  initial begin
    int pulses;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.pre_valid = 1'b0;
    bus.pre_sam   = '0;
    bus.org_blk   = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst:busy", int'(bus.busy), 0);
    check("rst:done", int'(bus.done), 0);
    check("rst:best_mode", int'(bus.best_mode), 0);
    check("rst:best_cost", int'(bus.best_cost), 0);

    // Exact match at mode 5; idle zero-SAD beats beforehand must not count.
    bus.org_blk = blk_ramp(0);
    for (int m = 0; m < 35; m++) pre_tab[m] = (m == 5) ? blk_ramp(0) : blk_ramp(1);
    bus.pre_sam   = bus.org_blk;
    bus.pre_valid = 1'b1;
    repeat (2) step();
    bus.pre_valid = 1'b0;
    do_search("exact", 1'b0, 5, cost_of(5, 0));

    // All modes SAD 16: lowest mode wins.
    bus.org_blk = blk_fill(100);
    for (int m = 0; m < 35; m++) pre_tab[m] = blk_fill(101);
    do_search("ties", 1'b0, 0, 16);

    // Same pattern with bubbles; gap beats carry a zero-SAD block.
    do_search("bubbles", 1'b1, 0, 16);

    // Max magnitude.
    bus.org_blk = blk_fill(0);
    for (int m = 0; m < 35; m++) pre_tab[m] = (m == 34) ? blk_fill(254) : blk_fill(255);
    do_search("max", 1'b0, 34, cost_of(34, 4064));

    // Reset after 20 beats.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int m = 0; m < 20; m++) begin
      bus.pre_sam   = pre_tab[m];
      bus.pre_valid = 1'b1;
      step();
    end
    bus.pre_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst:busy", int'(bus.busy), 0);
    check("midrst:done", int'(bus.done), 0);
    check("midrst:best_mode", int'(bus.best_mode), 0);
    check("midrst:best_cost", int'(bus.best_cost), 0);
    pulses = 0;
    bus.pre_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) pulses++;
    end
    bus.pre_valid = 1'b0;
    check("midrst:no_done", pulses, 0);
    do_search("after_rst", 1'b0, 34, cost_of(34, 4064));

    // Bias-sensitive pattern.
    bus.org_blk = blk_fill(50);
    for (int m = 0; m < 35; m++) pre_tab[m] = blk_sad(50, 100);
    pre_tab[0] = blk_sad(50, 10);
    pre_tab[7] = blk_sad(50, 8);
    if (BIAS != 0) do_search("bias", 1'b0, 0, 10);
    else           do_search("bias", 1'b0, 7, 8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
